// File: rtl/uec_uart_pkg.sv
// Shared types and constants for the IRAM dump path: FSM state encoding,
// UART frame length and clocks-per-bit helper.
package uec_uart_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        S_ADDR,
        S_HI,
        S_LO,
        NEXT,
        DONE
    } dump_state_t;

    function automatic int unsigned cpb(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. ready rises in the final clock of the stop bit so a
// byte offered in that cycle continues the line with no idle gap.
module uart_tx_byte
    import uec_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CPB   = cpb(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              active_q, active_d;
    logic              ready_q, ready_d;
    logic              tx_q, tx_d;
    logic              bit_end_c;
    logic              stop_bit_c;

    assign bit_end_c  = (baud_q == CNT_W'(CPB - 1));
    assign stop_bit_c = (bit_q == BIT_W'(FRAME_BITS - 1));

    // bit_q: 0 = start bit, 1..8 = d0..d7, 9 = stop bit
    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        active_d = active_q;
        ready_d  = ready_q;
        tx_d     = tx_q;
        if (valid && ready_q) begin
            data_d   = data;
            baud_d   = '0;
            bit_d    = '0;
            active_d = 1'b1;
            ready_d  = 1'b0;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (bit_end_c) begin
                baud_d = '0;
                if (stop_bit_c) begin
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                    tx_d  = (bit_q < BIT_W'(BYTE_W)) ? data_q[bit_q[2:0]] : 1'b1;
                end
            end else begin
                baud_d = baud_q + CNT_W'(1);
                if (stop_bit_c && (baud_q == CNT_W'(CPB - 2))) begin
                    ready_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            tx_q     <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;

endmodule

// File: rtl/send_memory.sv
// IRAM dump engine: walks [first_addr..last_addr] (wrapping) and sends each
// word as ADDR, DATA[15:8], DATA[7:0] over a UART line.
module send_memory
    import uec_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tx_valid_c;
    logic [7:0]        tx_byte_c;
    logic              tx_ready;

    // Each state offers the byte that follows the one currently on the line;
    // the last-word test sits in S_LO so done lands right after the stop bit.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_valid_c = 1'b0;
        tx_byte_c  = 8'(cur_q);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    busy_d  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                word_d     = rd_data;
                tx_valid_c = 1'b1;
                if (tx_ready) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                tx_byte_c  = word_q[DATA_W-1 -: 8];
                tx_valid_c = 1'b1;
                if (tx_ready) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                tx_byte_c  = word_q[7:0];
                tx_valid_c = 1'b1;
                if (tx_ready) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (tx_ready) begin
                    if (cur_q == last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                cur_d   = cur_q + ADDR_W'(1);
                state_d = READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_byte_c),
        .valid (tx_valid_c),
        .ready (tx_ready),
        .tx    (tx)
    );

    assign rd_addr = cur_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_send_memory.sv
// Directed bench for send_memory at CPB=16 with a 1-cycle-latency IRAM model
// and a mid-bit UART receiver logging bytes and their start cycles.
module tb_send_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  first_addr;
    logic [7:0]  last_addr;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= mem[rd_addr];

    send_memory #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .ADDR_W   (8),
        .DATA_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    // receiver / activity log, written only by this process
    logic [7:0] byte_log [0:255];
    int         byte_cyc [0:255];
    int         byte_n    = 0;
    int         frame_err = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         busy_rise = 0;
    int         busy_last = 0;
    bit         busy_prev = 1'b0;
    bit         m_act     = 1'b0;
    int         m_cnt     = 0;
    int         m_t0      = 0;
    logic [7:0] m_sh      = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if ((busy === 1'b1) && !busy_prev) busy_rise = cyc;
            if ((busy !== 1'b1) && busy_prev) busy_last = cyc - 1;
            busy_prev = (busy === 1'b1);
            if (rst === 1'b1) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (tx === 1'b0) begin
                    m_act = 1'b1;
                    m_cnt = 0;
                    m_t0  = cyc;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if ((m_cnt == 8) && (tx !== 1'b0)) frame_err = frame_err + 1;
                if ((m_cnt >= 24) && (m_cnt <= 136) && ((m_cnt % 16) == 8))
                    m_sh[3'((m_cnt - 24) / 16)] = tx;
                if (m_cnt == 152) begin
                    if (tx !== 1'b1) frame_err = frame_err + 1;
                    if (byte_n < 256) begin
                        byte_log[byte_n] = m_sh;
                        byte_cyc[byte_n] = m_t0;
                        byte_n = byte_n + 1;
                    end
                    m_act = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
        chk(tag, (idx < byte_n) ? 32'(byte_log[idx]) : 32'hDEAD, 32'(exp));
    endtask

    // issue a one-cycle start at the current cycle, then scramble the address inputs
    task automatic start_dump(input logic [7:0] f, input logic [7:0] l, output int s);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        s          = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        first_addr = ~f;
        last_addr  = ~l;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while ((done_cnt == base) && (n < budget)) begin
            @(negedge clk); #1;
            n = n + 1;
        end
        chk("done_seen", 32'(done_cnt != base), 32'd1);
    endtask

    initial begin
        int s;
        int s2;
        int b;
        int dbase;
        int quiet_bad;

        rst        = 1'b1;
        start      = 1'b0;
        first_addr = 8'h00;
        last_addr  = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h05] = 16'h1234;
        mem[8'h10] = 16'hA5A5;
        mem[8'h11] = 16'h0001;
        mem[8'h12] = 16'hFFFF;
        mem[8'hFE] = 16'hBEEF;
        mem[8'hFF] = 16'hCAFE;
        mem[8'h00] = 16'h0F0F;
        mem[8'h01] = 16'h1357;

        // reset and quiet idle
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((tx !== 1'b1) || (busy !== 1'b0) || (done !== 1'b0)) quiet_bad++;
        end
        chk("idle_quiet", 32'(quiet_bad), 32'd0);

        // single word at 0x05
        @(posedge clk); #1;
        b = byte_n;
        dbase = done_cnt;
        start_dump(8'h05, 8'h05, s);
        wait_done(2000);
        chk_byte("single_addr", b, 8'h05);
        chk_byte("single_hi", b + 1, 8'h12);
        chk_byte("single_lo", b + 2, 8'h34);
        chk("single_nbytes", 32'(byte_n - b), 32'd3);
        chk("single_txfall", 32'(byte_cyc[b] - s), 32'd3);
        chk("single_done_cyc", 32'(done_cyc - s), 32'd483);
        chk("single_busy_rise", 32'(busy_rise - s), 32'd1);
        chk("single_busy_last", 32'(busy_last - s), 32'd482);
        chk("single_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // three-word range with inter-word gap
        @(posedge clk); #1;
        b = byte_n;
        start_dump(8'h10, 8'h12, s);
        wait_done(5000);
        chk_byte("range_b0", b + 0, 8'h10);
        chk_byte("range_b1", b + 1, 8'hA5);
        chk_byte("range_b2", b + 2, 8'hA5);
        chk_byte("range_b3", b + 3, 8'h11);
        chk_byte("range_b4", b + 4, 8'h00);
        chk_byte("range_b5", b + 5, 8'h01);
        chk_byte("range_b6", b + 6, 8'h12);
        chk_byte("range_b7", b + 7, 8'hFF);
        chk_byte("range_b8", b + 8, 8'hFF);
        chk("range_nbytes", 32'(byte_n - b), 32'd9);
        chk("range_intra", 32'(byte_cyc[b + 1] - byte_cyc[b]), 32'd160);
        chk("range_gap1", 32'(byte_cyc[b + 3] - byte_cyc[b + 2]), 32'd163);
        chk("range_gap2", 32'(byte_cyc[b + 6] - byte_cyc[b + 5]), 32'd163);

        // wrap FE..01
        @(posedge clk); #1;
        b = byte_n;
        dbase = done_cnt;
        start_dump(8'hFE, 8'h01, s);
        wait_done(3000);
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        chk_byte("wrap_b0", b + 0, 8'hFE);
        chk_byte("wrap_b1", b + 1, 8'hBE);
        chk_byte("wrap_b2", b + 2, 8'hEF);
        chk_byte("wrap_b3", b + 3, 8'hFF);
        chk_byte("wrap_b4", b + 4, 8'hCA);
        chk_byte("wrap_b5", b + 5, 8'hFE);
        chk_byte("wrap_b6", b + 6, 8'h00);
        chk_byte("wrap_b7", b + 7, 8'h0F);
        chk_byte("wrap_b8", b + 8, 8'h0F);
        chk_byte("wrap_b9", b + 9, 8'h01);
        chk_byte("wrap_b10", b + 10, 8'h13);
        chk_byte("wrap_b11", b + 11, 8'h57);
        chk("wrap_nbytes", 32'(byte_n - b), 32'd12);
        chk("wrap_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("wrap_busy_idle", 32'(busy), 32'd0);

        // start while busy ignored; start one cycle after done accepted
        @(posedge clk); #1;
        b = byte_n;
        dbase = done_cnt;
        start_dump(8'h05, 8'h05, s);
        repeat (49) @(posedge clk);
        #1;
        first_addr = 8'h10;
        last_addr  = 8'h12;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        wait_done(2000);
        chk("busy_done_cyc", 32'(done_cyc - s), 32'd483);
        @(posedge clk); #1;
        start_dump(8'h11, 8'h11, s2);
        chk("restart_gap", 32'(s2 - done_cyc), 32'd1);
        wait_done(2000);
        chk_byte("busy_b0", b + 0, 8'h05);
        chk_byte("busy_b1", b + 1, 8'h12);
        chk_byte("busy_b2", b + 2, 8'h34);
        chk_byte("restart_b0", b + 3, 8'h11);
        chk_byte("restart_b1", b + 4, 8'h00);
        chk_byte("restart_b2", b + 5, 8'h01);
        chk("restart_txfall", 32'(byte_cyc[b + 3] - s2), 32'd3);
        chk("restart_done_cnt", 32'(done_cnt - dbase), 32'd2);

        // reset during d4 of the second byte
        @(posedge clk); #1;
        b = byte_n;
        dbase = done_cnt;
        start_dump(8'h10, 8'h12, s);
        repeat (249) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
        chk_byte("midrst_b0", b, 8'h10);
        chk("midrst_nbytes", 32'(byte_n - b), 32'd1);
        chk("midrst_no_done", 32'(done_cnt - dbase), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        b = byte_n;
        start_dump(8'h12, 8'h12, s);
        wait_done(2000);
        chk_byte("after_b0", b + 0, 8'h12);
        chk_byte("after_b1", b + 1, 8'hFF);
        chk_byte("after_b2", b + 2, 8'hFF);
        chk("after_txfall", 32'(byte_cyc[b] - s), 32'd3);
        chk("frame_errors", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
